// File: rtl/method_call_initiator_if.sv
// Req/busy method-call handshake between an initiator and a generated callee.
interface method_call_initiator_if;
  logic call_req;
  logic call_busy;

  modport master (output call_req, input call_busy);
  modport slave  (input call_req, output call_busy);
endinterface

// File: rtl/method_call_initiator.sv
// Issues a programmable number of back-to-back calls over a req/busy handshake,
// measuring per-call latency and total run time, and aborting on timeout.
module method_call_initiator #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ITER_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ITER_WIDTH-1:0]     iterations,
  method_call_initiator_if.master   mc,
  output logic                      running,
  output logic                      done,
  output logic                      error,
  output logic [ITER_WIDTH-1:0]     completed,
  output logic [CNT_WIDTH-1:0]      last_latency,
  output logic [CNT_WIDTH-1:0]      total_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  // Abort when the counter would reach TIMEOUT-1 on this edge.
  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_REQ, S_RUN, S_GAP, S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [CNT_WIDTH-1:0]  lat_q, lat_d;
  logic                  call_req_q, call_req_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ITER_WIDTH-1:0] completed_q, completed_d;
  logic [CNT_WIDTH-1:0]  last_latency_q, last_latency_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;

  logic [CNT_WIDTH-1:0]  lat_inc;
  logic [ITER_WIDTH-1:0] completed_inc;
  logic                  timeout_hit;

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    lat_d          = lat_q;
    call_req_d     = 1'b0;
    running_d      = running_q;
    done_d         = 1'b0;
    error_d        = error_q;
    completed_d    = completed_q;
    last_latency_d = last_latency_q;
    total_d        = total_q;

    lat_inc       = (lat_q == CNT_MAX) ? lat_q : lat_q + CNT_WIDTH'(1);
    completed_inc = completed_q + ITER_WIDTH'(1);
    timeout_hit   = (lat_q >= TO_LIMIT);

    if (running_q && total_q != CNT_MAX) begin
      total_d = total_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d      = iterations;
          completed_d = '0;
          error_d     = 1'b0;
          total_d     = '0;
          lat_d       = '0;
          running_d   = 1'b1;
          state_d     = (iterations == '0) ? S_FIN : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!mc.call_busy) begin
          lat_d      = '0;
          call_req_d = 1'b1;
          state_d    = S_REQ;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          lat_d = lat_inc;
        end
      end
      S_REQ: begin
        lat_d = lat_inc;
        if (mc.call_busy) begin
          state_d = S_RUN;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          call_req_d = 1'b1;
        end
      end
      S_RUN: begin
        lat_d = lat_inc;
        if (!mc.call_busy) begin
          last_latency_d = lat_inc;
          completed_d    = completed_inc;
          state_d        = (completed_inc < iter_q) ? S_GAP : S_FIN;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_GAP: begin
        lat_d   = '0;
        state_d = S_WAIT_IDLE;
      end
      S_FIN: begin
        done_d    = 1'b1;
        running_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      iter_q         <= '0;
      lat_q          <= '0;
      call_req_q     <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      completed_q    <= '0;
      last_latency_q <= '0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      lat_q          <= lat_d;
      call_req_q     <= call_req_d;
      running_q      <= running_d;
      done_q         <= done_d;
      error_q        <= error_d;
      completed_q    <= completed_d;
      last_latency_q <= last_latency_d;
      total_q        <= total_d;
    end
  end

  assign mc.call_req   = call_req_q;
  assign running       = running_q;
  assign done          = done_q;
  assign error         = error_q;
  assign completed     = completed_q;
  assign last_latency  = last_latency_q;
  assign total_cycles  = total_q;

endmodule
